// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage RV32 core.
// Handles load-use stalls of configurable length, holds the front end while a multi-cycle
// mul/div occupies EX, and flushes IF/ID and ID/EX on an EX-stage redirect. Also keeps a
// saturating count of cycles in which the PC was not written.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MD_LAT   = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_reg_write,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_md_start,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic              if_id_rs1_used,
  input  logic              if_id_rs2_used,
  input  logic              ex_redirect,
  output logic              pc_wr,
  output logic              if_id_wr,
  output logic              id_ex_wr,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [1:0]        stall,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Stall cause encoding on the stall output.
  localparam logic [1:0] StallNone     = 2'b00;
  localparam logic [1:0] StallLoadUse  = 2'b01;
  localparam logic [1:0] StallMulDiv   = 2'b10;
  localparam logic [1:0] StallRedirect = 2'b11;

  // The counter must hold the larger of the two reload values.
  localparam int unsigned MaxLat = (MD_LAT > LOAD_LAT) ? MD_LAT : LOAD_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat) + 1;

  // cnt holds the number of further stall-state cycles after the current one. The cycle that
  // detects the hazard is itself a frozen cycle, so a load-use stall spends LOAD_LAT-1 cycles
  // in LU_STALL and a mul/div spends MD_LAT-2 cycles in MD_BUSY (front end frozen MD_LAT-1
  // cycles, so the mul/div instruction occupies EX for MD_LAT cycles in total).
  localparam logic [CntW-1:0] LuInit = CntW'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
  localparam logic [CntW-1:0] MdInit = CntW'((MD_LAT > 2) ? MD_LAT - 3 : 0);

  typedef enum logic [1:0] {
    StIdle,
    StLuStall,
    StMdBusy
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic              rs1_hit, rs2_hit, lu_hit;

  // Load-use hazard: a load in EX writes a non-zero rd that the ID instruction really reads.
  always_comb begin
    rs1_hit = if_id_rs1_used && (if_id_rs1 == id_ex_rd);
    rs2_hit = if_id_rs2_used && (if_id_rs2 == id_ex_rd);
    lu_hit  = id_ex_mem_read && id_ex_reg_write && (id_ex_rd != '0) && (rs1_hit || rs2_hit);
  end

  // Next-state and output decode; outputs stay at their pass-through defaults during reset.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_wr        = 1'b1;
    if_id_wr     = 1'b1;
    id_ex_wr     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    stall        = StallNone;

    if (rstn) begin
      unique case (state_q)
        StIdle: begin
          if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            stall       = StallRedirect;
          end else if (id_ex_md_start) begin
            pc_wr        = 1'b0;
            if_id_wr     = 1'b0;
            id_ex_wr     = 1'b0;
            ex_mem_flush = 1'b1;
            stall        = StallMulDiv;
            if (MD_LAT > 2) begin
              state_d = StMdBusy;
              cnt_d   = MdInit;
            end
          end else if (lu_hit) begin
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            id_ex_flush = 1'b1;
            stall       = StallLoadUse;
            if (LOAD_LAT > 1) begin
              state_d = StLuStall;
              cnt_d   = LuInit;
            end
          end
        end

        StLuStall: begin
          if (ex_redirect) begin
            // The load's consumer is being squashed, so the stall is abandoned.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            stall       = StallRedirect;
            state_d     = StIdle;
            cnt_d       = '0;
          end else begin
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            id_ex_flush = 1'b1;
            stall       = StallLoadUse;
            if (cnt_q == '0) begin
              state_d = StIdle;
            end else begin
              cnt_d = cnt_q - CntW'(1);
            end
          end
        end

        StMdBusy: begin
          // EX is owned by the mul/div; redirect and new hazards wait until it drains.
          pc_wr        = 1'b0;
          if_id_wr     = 1'b0;
          id_ex_wr     = 1'b0;
          ex_mem_flush = 1'b1;
          stall        = StallMulDiv;
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end

        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Saturating count of frozen-PC cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_wr && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // State, remaining-cycle counter and stall counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

  // A frozen PC always comes with a load-use or mul/div cause.
  a_pc_freeze_cause : assert property (@(posedge clk) disable iff (!rstn)
    !pc_wr |-> (stall == StallLoadUse || stall == StallMulDiv));

  // ID/EX is never written while a mul/div still occupies EX.
  a_md_holds_id_ex : assert property (@(posedge clk) disable iff (!rstn)
    (state_q == StMdBusy) |-> !id_ex_wr);

  // The remaining-cycle counter never exceeds its largest reload value.
  a_cnt_bound : assert property (@(posedge clk) disable iff (!rstn)
    (cnt_q <= LuInit) || (cnt_q <= MdInit));

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: two instances (LOAD_LAT=1/CNT_W=32 and
// LOAD_LAT=3/CNT_W=2, both MD_LAT=4) share one set of inputs.
module tb_hazard_ctrl_unit;

  // Packed output vectors: {pc_wr, if_id_wr, id_ex_wr, if_id_flush, id_ex_flush,
  // ex_mem_flush, stall[1:0]}.
  localparam logic [7:0] DEF = 8'b111_000_00;
  localparam logic [7:0] LU  = 8'b001_010_01;
  localparam logic [7:0] MD  = 8'b000_001_10;
  localparam logic [7:0] RED = 8'b111_110_11;

  logic       clk;
  logic       rstn;
  logic       mem_read, reg_write, md_start, rs1_used, rs2_used, redirect;
  logic [4:0] rd, rs1, rs2;

  logic       pc_wr_a, if_id_wr_a, id_ex_wr_a, if_id_flush_a, id_ex_flush_a, ex_mem_flush_a;
  logic [1:0] stall_a;
  logic [31:0] cnt_a;
  logic       pc_wr_b, if_id_wr_b, id_ex_wr_b, if_id_flush_b, id_ex_flush_b, ex_mem_flush_b;
  logic [1:0] stall_b;
  logic [1:0] cnt_b;

  logic [7:0] outs_a, outs_b;
  assign outs_a = {pc_wr_a, if_id_wr_a, id_ex_wr_a, if_id_flush_a, id_ex_flush_a,
                   ex_mem_flush_a, stall_a};
  assign outs_b = {pc_wr_b, if_id_wr_b, id_ex_wr_b, if_id_flush_b, id_ex_flush_b,
                   ex_mem_flush_b, stall_b};

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .MD_LAT(4), .CNT_W(32)) dut_a (
    .clk(clk), .rstn(rstn),
    .id_ex_mem_read(mem_read), .id_ex_reg_write(reg_write), .id_ex_rd(rd),
    .id_ex_md_start(md_start), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used), .ex_redirect(redirect),
    .pc_wr(pc_wr_a), .if_id_wr(if_id_wr_a), .id_ex_wr(id_ex_wr_a),
    .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a), .ex_mem_flush(ex_mem_flush_a),
    .stall(stall_a), .stall_cycles(cnt_a)
  );

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .MD_LAT(4), .CNT_W(2)) dut_b (
    .clk(clk), .rstn(rstn),
    .id_ex_mem_read(mem_read), .id_ex_reg_write(reg_write), .id_ex_rd(rd),
    .id_ex_md_start(md_start), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used), .ex_redirect(redirect),
    .pc_wr(pc_wr_b), .if_id_wr(if_id_wr_b), .id_ex_wr(id_ex_wr_b),
    .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b), .ex_mem_flush(ex_mem_flush_b),
    .stall(stall_b), .stall_cycles(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       mr, rw, md, u1, u2, redir;
    logic [4:0] rd, rs1, rs2;
    logic [7:0] exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   exp_a  = 0;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic mr, input logic rw, input logic [4:0] d, input logic md,
                        input logic [4:0] s1, input logic [4:0] s2, input logic u1,
                        input logic u2, input logic redir);
    mem_read  = mr;
    reg_write = rw;
    rd        = d;
    md_start  = md;
    rs1       = s1;
    rs2       = s2;
    rs1_used  = u1;
    rs2_used  = u2;
    redirect  = redir;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // lw x5 in EX, ID instruction reads x5 through rs1.
  task automatic lu_in();
    set_in(1'b1, 1'b1, 5'd5, 1'b0, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0);
  endtask

  function automatic vec_t mk(input string n, input logic mr, input logic rw,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic u1, input logic u2, input logic redir,
                              input logic [7:0] e);
    vec_t v;
    v.name = n; v.mr = mr; v.rw = rw; v.rd = d; v.md = 1'b0; v.rs1 = s1; v.rs2 = s2;
    v.u1 = u1; v.u2 = u2; v.redir = redir; v.exp = e;
    return v;
  endfunction

  initial begin
    //            name            mr    rw    rd     rs1    rs2    u1    u2    redir exp
    vecs[0] = mk("lu_rs1",       1'b1, 1'b1, 5'd5,  5'd5,  5'd9,  1'b1, 1'b1, 1'b0, LU);
    vecs[1] = mk("after_lu",     1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, DEF);
    vecs[2] = mk("rd_x0",        1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, DEF);
    vecs[3] = mk("rs2_unused",   1'b1, 1'b1, 5'd6,  5'd1,  5'd6,  1'b1, 1'b0, 1'b0, DEF);
    vecs[4] = mk("lu_rs2",       1'b1, 1'b1, 5'd6,  5'd1,  5'd6,  1'b1, 1'b1, 1'b0, LU);
    vecs[5] = mk("no_regwrite",  1'b1, 1'b0, 5'd6,  5'd6,  5'd6,  1'b1, 1'b1, 1'b0, DEF);
    vecs[6] = mk("not_load",     1'b0, 1'b1, 5'd6,  5'd6,  5'd6,  1'b1, 1'b1, 1'b0, DEF);
    vecs[7] = mk("redirect",     1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, RED);
    vecs[8] = mk("redir_and_lu", 1'b1, 1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1, RED);
    vecs[9] = mk("rs1_unused",   1'b1, 1'b1, 5'd3,  5'd3,  5'd4,  1'b0, 1'b1, 1'b0, DEF);

    // Reset: outputs forced to defaults even with a live load-use hazard on the inputs.
    rstn = 1'b0;
    idle_in();
    @(negedge clk); lu_in(); #2;
    chk("rst_out_a", 32'(outs_a), 32'(DEF));
    chk("rst_out_b", 32'(outs_b), 32'(DEF));
    @(negedge clk); #2;
    chk("rst_cnt_a", cnt_a, 32'd0);
    chk("rst_cnt_b", 32'(cnt_b), 32'd0);
    @(negedge clk); rstn = 1'b1; idle_in();

    // Single-cycle decode on the LOAD_LAT=1 instance.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_in(vecs[i].mr, vecs[i].rw, vecs[i].rd, vecs[i].md, vecs[i].rs1, vecs[i].rs2,
             vecs[i].u1, vecs[i].u2, vecs[i].redir);
      #2;
      chk(vecs[i].name, 32'(outs_a), 32'(vecs[i].exp));
      chk({vecs[i].name, "_cnt"}, cnt_a, 32'(exp_a));
      if (!vecs[i].exp[7]) exp_a++;
    end
    @(negedge clk); idle_in(); #2;
    chk("table_cnt_a", cnt_a, 32'd2);

    // Fresh start for the multi-cycle sequences.
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;

    // LOAD_LAT=3: one-cycle hazard gives three stall cycles on dut_b, one on dut_a.
    @(negedge clk); lu_in(); #2;
    chk("lu3_c1_b", 32'(outs_b), 32'(LU));
    chk("lu1_c1_a", 32'(outs_a), 32'(LU));
    @(negedge clk); idle_in(); #2;
    chk("lu3_c2_b", 32'(outs_b), 32'(LU));
    chk("lu1_c2_a", 32'(outs_a), 32'(DEF));
    @(negedge clk); #2;
    chk("lu3_c3_b", 32'(outs_b), 32'(LU));
    @(negedge clk); #2;
    chk("lu3_c4_b", 32'(outs_b), 32'(DEF));
    chk("lu3_cnt_b", 32'(cnt_b), 32'd3);
    chk("lu1_cnt_a", cnt_a, 32'd1);

    // Second load-use stall: the 2-bit counter stays at 3.
    @(negedge clk); lu_in(); #2;
    chk("sat_c1_b", 32'(outs_b), 32'(LU));
    @(negedge clk); idle_in();
    @(negedge clk);
    @(negedge clk); #2;
    chk("sat_c4_b", 32'(outs_b), 32'(DEF));
    chk("sat_cnt_b", 32'(cnt_b), 32'd3);
    chk("sat_cnt_a", cnt_a, 32'd2);

    // MD_LAT=4: md_start beats lu_hit, three frozen cycles, mid-busy redirect ignored.
    @(negedge clk); lu_in(); md_start = 1'b1; #2;
    chk("md_c1_a", 32'(outs_a), 32'(MD));
    chk("md_c1_b", 32'(outs_b), 32'(MD));
    @(negedge clk); idle_in(); redirect = 1'b1; #2;
    chk("md_c2_redir_a", 32'(outs_a), 32'(MD));
    chk("md_c2_redir_b", 32'(outs_b), 32'(MD));
    @(negedge clk); idle_in(); #2;
    chk("md_c3_a", 32'(outs_a), 32'(MD));
    chk("md_c3_b", 32'(outs_b), 32'(MD));
    @(negedge clk); #2;
    chk("md_c4_a", 32'(outs_a), 32'(DEF));
    chk("md_c4_b", 32'(outs_b), 32'(DEF));
    chk("md_cnt_a", cnt_a, 32'd5);

    // Redirect with lu_hit in IDLE: redirect wins and LU_STALL is not entered.
    @(negedge clk); lu_in(); redirect = 1'b1; #2;
    chk("redir_lu_b", 32'(outs_b), 32'(RED));
    chk("redir_lu_a", 32'(outs_a), 32'(RED));
    @(negedge clk); idle_in(); #2;
    chk("redir_lu_next_b", 32'(outs_b), 32'(DEF));

    // Redirect while in LU_STALL aborts the stall.
    @(negedge clk); lu_in(); #2;
    chk("abort_c1_b", 32'(outs_b), 32'(LU));
    @(negedge clk); idle_in(); redirect = 1'b1; #2;
    chk("abort_c2_b", 32'(outs_b), 32'(RED));
    @(negedge clk); idle_in(); #2;
    chk("abort_c3_b", 32'(outs_b), 32'(DEF));
    chk("abort_cnt_a", cnt_a, 32'd6);

    // Reset during LU_STALL cycle 2: defaults while low, IDLE and cleared counters after.
    @(negedge clk); lu_in(); #2;
    chk("rstlu_c1_b", 32'(outs_b), 32'(LU));
    @(negedge clk); rstn = 1'b0; #2;
    chk("rstlu_c2_b", 32'(outs_b), 32'(DEF));
    chk("rstlu_c2_a", 32'(outs_a), 32'(DEF));
    @(negedge clk); rstn = 1'b1; idle_in(); #2;
    chk("rstlu_c3_b", 32'(outs_b), 32'(DEF));
    chk("rstlu_cnt_b", 32'(cnt_b), 32'd0);
    chk("rstlu_cnt_a", cnt_a, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
